// File: rtl/serdesphy_pkg.sv
// Shared definitions for the serdesphy serializer/deserializer pair.
package serdesphy_pkg;

    // Default parallel word width used by both directions of the link.
    localparam int SERDES_WIDTH = 16;

    // Two-state sequencing shared by serializer and deserializer.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } serdes_state_e;

endpackage : serdesphy_pkg

// File: rtl/serdesphy_ana_serializer.sv
// Parallel-to-serial converter, LSB first, with a one-word holding register
// so a gapless stream can be sustained.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | nothing in flight, serial_out parked at 0, waiting for a word
//  ST_SHIFT | shift register driving serial_out, counter tracks bit index
module serdesphy_ana_serializer
    import serdesphy_pkg::*;
#(
    parameter int WIDTH = SERDES_WIDTH
) (
    input  logic             clk_240m_tx,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             underrun
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    serdes_state_e    state;
    serdes_state_e    state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic end_of_word;
    logic load_in;
    logic load_from_hold;
    logic load_hold;
    logic shift_en;
    logic go_idle;

    // Ready depends only on registered state and the enable/reset inputs,
    // never on data_valid, so upstream can't form a combinational loop.
    assign data_ready  = enable & rst_n & ~hold_full;
    assign accept      = data_valid & data_ready;
    assign end_of_word = (cnt == LAST_BIT);
    assign serial_out  = shift_reg[0];
    assign busy        = (state == ST_SHIFT) | hold_full;

    // State register.
    always_ff @(posedge clk_240m_tx or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        state_next     = state;
        load_in        = 1'b0;
        load_from_hold = 1'b0;
        load_hold      = 1'b0;
        shift_en       = 1'b0;
        go_idle        = 1'b0;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        load_in    = 1'b1;
                        state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (end_of_word) begin
                        // Priority: queued word, then a word arriving right now
                        // (bypass), otherwise the stream has run dry.
                        if (hold_full) begin
                            load_from_hold = 1'b1;
                        end else if (accept) begin
                            load_in = 1'b1;
                        end else begin
                            go_idle    = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end else begin
                        shift_en  = 1'b1;
                        load_hold = accept;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Shift register, bit counter, holding register and underrun flag.
    always_ff @(posedge clk_240m_tx or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            underrun  <= 1'b0;
        end else if (!enable) begin
            // Abort: discard the partial word and anything queued, silently.
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= go_idle;
            if (load_in) begin
                shift_reg <= parallel_in;
                cnt       <= '0;
            end else if (load_from_hold) begin
                shift_reg <= hold_reg;
                cnt       <= '0;
            end else if (go_idle) begin
                shift_reg <= '0;
                cnt       <= '0;
            end else if (shift_en) begin
                shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
                cnt       <= cnt + CNT_W'(1);
            end
            if (load_hold) begin
                hold_reg  <= parallel_in;
                hold_full <= 1'b1;
            end else if (load_from_hold) begin
                hold_reg  <= '0;
                hold_full <= 1'b0;
            end
        end
    end

endmodule : serdesphy_ana_serializer

// File: tb/tb_serdesphy_ana_serializer.sv
// Directed bench for the serializer: single word, back-to-back, bypass,
// abort and asynchronous reset scenarios.
module tb_serdesphy_ana_serializer;

    localparam int W = 16;

    logic         clk_240m_tx;
    logic         rst_n;
    logic         enable;
    logic [W-1:0] parallel_in;
    logic         data_valid;
    logic         data_ready;
    logic         serial_out;
    logic         busy;
    logic         underrun;

    int vec_cnt;
    int err_cnt;

    serdesphy_ana_serializer #(.WIDTH(W)) dut (
        .clk_240m_tx (clk_240m_tx),
        .rst_n       (rst_n),
        .enable      (enable),
        .parallel_in (parallel_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .serial_out  (serial_out),
        .busy        (busy),
        .underrun    (underrun)
    );

    initial clk_240m_tx = 1'b0;
    always #5 clk_240m_tx = ~clk_240m_tx;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk_240m_tx);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        enable      = 1'b1;
        data_valid  = 1'b1;
        parallel_in = 16'hFFFF;
        repeat (3) tick();
        vec_cnt++;
        if ({serial_out, busy, underrun, data_ready} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_outputs: got {ser,busy,und,rdy}=%b want 0000",
                     {serial_out, busy, underrun, data_ready});
        end
        data_valid = 1'b0;
        @(negedge clk_240m_tx);
        rst_n = 1'b1;
        tick();
        vec_cnt++;
        if ({serial_out, busy, underrun, data_ready} !== 4'b0001) begin
            err_cnt++;
            $display("FAIL reset_release: got {ser,busy,und,rdy}=%b want 0001",
                     {serial_out, busy, underrun, data_ready});
        end
    endtask

    task automatic test_single();
        logic [W-1:0] bits;
        logic         busy_ok;
        bits    = '0;
        busy_ok = 1'b1;
        parallel_in = 16'hA5C3;
        data_valid  = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 1; i <= W; i++) begin
            bits[i-1] = serial_out;
            if (busy !== 1'b1 || underrun !== 1'b0) busy_ok = 1'b0;
            tick();
        end
        vec_cnt++;
        if (bits !== 16'hA5C3) begin
            err_cnt++;
            $display("FAIL single_bits: got %h want a5c3", bits);
        end
        vec_cnt++;
        if (busy_ok !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_busy: busy/underrun wrong during cycles 1..16");
        end
        vec_cnt++;
        if ({serial_out, underrun, busy} !== 3'b010) begin
            err_cnt++;
            $display("FAIL single_underrun: got {ser,und,busy}=%b want 010",
                     {serial_out, underrun, busy});
        end
        tick();
        vec_cnt++;
        if ({serial_out, underrun, busy} !== 3'b000) begin
            err_cnt++;
            $display("FAIL single_after: got {ser,und,busy}=%b want 000",
                     {serial_out, underrun, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] bits;
        logic           rdy_ok;
        logic           und_ok;
        bits   = '0;
        rdy_ok = 1'b1;
        und_ok = 1'b1;
        parallel_in = 16'hFFFF;
        data_valid  = 1'b1;
        tick();
        bits[0]     = serial_out;
        parallel_in = 16'h0000;
        vec_cnt++;
        if (data_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_ready_first: got %b want 1", data_ready);
        end
        tick();
        data_valid = 1'b0;
        for (int j = 2; j <= 2*W; j++) begin
            bits[j-1] = serial_out;
            if (data_ready !== ((j <= W) ? 1'b0 : 1'b1)) rdy_ok = 1'b0;
            if (underrun !== 1'b0) und_ok = 1'b0;
            if (j < 2*W) tick();
        end
        vec_cnt++;
        if (bits !== 32'h0000_FFFF) begin
            err_cnt++;
            $display("FAIL b2b_bits: got %h want 0000ffff", bits);
        end
        vec_cnt++;
        if (rdy_ok !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_ready: data_ready wrong while holding register full");
        end
        vec_cnt++;
        if (und_ok !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_no_underrun: underrun pulsed inside the stream");
        end
        tick();
        vec_cnt++;
        if (underrun !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_underrun_end: got %b want 1", underrun);
        end
        tick();
    endtask

    task automatic test_bypass();
        logic [2*W-1:0] bits;
        logic           und_ok;
        bits   = '0;
        und_ok = 1'b1;
        parallel_in = 16'h8001;
        data_valid  = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int j = 1; j <= 2*W; j++) begin
            bits[j-1] = serial_out;
            if (underrun !== 1'b0) und_ok = 1'b0;
            if (j == W) begin
                parallel_in = 16'h0001;
                data_valid  = 1'b1;
                vec_cnt++;
                if ({data_ready, busy} !== 2'b11) begin
                    err_cnt++;
                    $display("FAIL bypass_ready: got {rdy,busy}=%b want 11", {data_ready, busy});
                end
            end
            tick();
            data_valid = 1'b0;
        end
        vec_cnt++;
        if (bits !== 32'h0001_8001) begin
            err_cnt++;
            $display("FAIL bypass_bits: got %h want 00018001", bits);
        end
        vec_cnt++;
        if (und_ok !== 1'b1) begin
            err_cnt++;
            $display("FAIL bypass_no_underrun: underrun pulsed at the bypass boundary");
        end
        vec_cnt++;
        if (underrun !== 1'b1) begin
            err_cnt++;
            $display("FAIL bypass_underrun_end: got %b want 1", underrun);
        end
        tick();
    endtask

    task automatic test_abort();
        logic [5:0]   head;
        logic [W-1:0] bits;
        logic         und_ok;
        logic         idle_ok;
        head    = '0;
        bits    = '0;
        und_ok  = 1'b1;
        idle_ok = 1'b1;
        parallel_in = 16'h1234;
        data_valid  = 1'b1;
        tick();
        head[0]     = serial_out;
        parallel_in = 16'h5678;
        tick();
        data_valid = 1'b0;
        vec_cnt++;
        if ({busy, data_ready} !== 2'b10) begin
            err_cnt++;
            $display("FAIL abort_hold_full: got {busy,rdy}=%b want 10", {busy, data_ready});
        end
        for (int j = 2; j <= 6; j++) begin
            head[j-1] = serial_out;
            if (j < 6) tick();
        end
        vec_cnt++;
        if (head !== 6'h34) begin
            err_cnt++;
            $display("FAIL abort_head_bits: got %h want 34", head);
        end
        enable = 1'b0;
        tick();
        vec_cnt++;
        if ({serial_out, busy, data_ready, underrun} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL abort_outputs: got {ser,busy,rdy,und}=%b want 0000",
                     {serial_out, busy, data_ready, underrun});
        end
        for (int j = 0; j < 20; j++) begin
            if (underrun !== 1'b0) und_ok = 1'b0;
            tick();
        end
        vec_cnt++;
        if (und_ok !== 1'b1) begin
            err_cnt++;
            $display("FAIL abort_no_underrun: underrun pulsed while disabled");
        end
        enable = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if ({serial_out, busy} !== 2'b00) idle_ok = 1'b0;
            tick();
        end
        vec_cnt++;
        if (idle_ok !== 1'b1) begin
            err_cnt++;
            $display("FAIL reenable_quiet: bits emitted before a new accept");
        end
        parallel_in = 16'h00FF;
        data_valid  = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int j = 1; j <= W; j++) begin
            bits[j-1] = serial_out;
            tick();
        end
        vec_cnt++;
        if (bits !== 16'h00FF) begin
            err_cnt++;
            $display("FAIL reenable_bits: got %h want 00ff", bits);
        end
        vec_cnt++;
        if (underrun !== 1'b1) begin
            err_cnt++;
            $display("FAIL reenable_underrun: got %b want 1", underrun);
        end
        tick();
    endtask

    task automatic test_async_reset();
        logic [W-1:0] bits;
        bits = '0;
        parallel_in = 16'hBEEF;
        data_valid  = 1'b1;
        tick();
        parallel_in = 16'h1111;
        tick();
        data_valid = 1'b0;
        repeat (8) tick();
        vec_cnt++;
        if ({serial_out, busy} !== 2'b11) begin
            err_cnt++;
            $display("FAIL areset_pre: got {ser,busy}=%b want 11", {serial_out, busy});
        end
        rst_n = 1'b0;
        #2;
        vec_cnt++;
        if ({serial_out, busy, underrun, data_ready} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL areset_immediate: got {ser,busy,und,rdy}=%b want 0000",
                     {serial_out, busy, underrun, data_ready});
        end
        @(negedge clk_240m_tx);
        rst_n = 1'b1;
        parallel_in = 16'h3C5A;
        data_valid  = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int j = 1; j <= W; j++) begin
            bits[j-1] = serial_out;
            tick();
        end
        vec_cnt++;
        if (bits !== 16'h3C5A) begin
            err_cnt++;
            $display("FAIL areset_after_bits: got %h want 3c5a", bits);
        end
        vec_cnt++;
        if (underrun !== 1'b1) begin
            err_cnt++;
            $display("FAIL areset_after_underrun: got %b want 1", underrun);
        end
        tick();
    endtask

    initial begin
        vec_cnt     = 0;
        err_cnt     = 0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        data_valid  = 1'b0;
        parallel_in = '0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_bypass();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_serdesphy_ana_serializer

// File: doc/serdesphy_ana_serializer.md
SERDESPHY_ANA_SERIALIZER -- requirements
Module: serdesphy_ana_serializer

Interface
REQ-001 Parameter: WIDTH, default 16, parallel word width in bits.
REQ-002 clk_240m_tx  input  1  240 MHz transmit bit clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 enable  input  1  serializer enable; low aborts all activity.
REQ-005 parallel_in  input  WIDTH  word to transmit; sampled only on an accept edge.
REQ-006 data_valid  input  1  upstream asserts while parallel_in holds a valid word.
REQ-007 data_ready  output  1  serializer can take a word this cycle.
REQ-008 serial_out  output  1  serial bit stream, registered, LSB first.
REQ-009 busy  output  1  word in flight or pending.
REQ-010 underrun  output  1  one-cycle pulse when the stream ends for lack of data.

Function
REQ-011 Accept: a word transfers on a rising edge where data_valid=1 and data_ready=1; no other edge consumes it.
REQ-012 data_ready = enable AND holding register empty; combinational from registered state only, never from data_valid.
REQ-013 FSM has two states: IDLE and SHIFT.
REQ-014 IDLE + accept: word loads directly into the shift register, bit counter = 0, next state SHIFT; holding stays empty.
REQ-015 Latency: bit 0 of an accepted word appears on serial_out in the cycle immediately after the accept edge; bits 1..WIDTH-1 follow on consecutive cycles.
REQ-016 SHIFT: each edge shifts right one bit and increments the bit counter (log2 WIDTH bits, wraps WIDTH-1 -> 0).
REQ-017 SHIFT + accept with counter != WIDTH-1: word loads into the holding register.
REQ-018 End of word (counter = WIDTH-1) with holding full: holding moves into the shift register and becomes empty; bit 0 of the next word follows the previous bit WIDTH-1 with no gap.
REQ-019 End of word with holding empty and simultaneous accept: word bypasses the holding register straight into the shift register, no gap, no underrun.
REQ-020 End of word with holding empty and no accept: next state IDLE, underrun = 1 for exactly the next cycle.
REQ-021 serial_out = 0 in IDLE and for the cycle after any abort.
REQ-022 busy = (state == SHIFT) OR holding full.
REQ-023 enable low on any edge: state -> IDLE, holding cleared, counter = 0, serial_out = 0, no underrun pulse; the partial word is discarded.
REQ-024 enable rising: no bit is emitted until a new accept.

Reset
REQ-025 While rst_n = 0: state IDLE, shift register 0, holding empty and 0, counter 0, serial_out 0, busy 0, underrun 0, data_ready 0.
REQ-026 Reset asserted mid-word aborts immediately with the REQ-025 values; release is synchronized externally and the block needs no extra cycles after release.

Structure
REQ-027 The FSM state encoding (IDLE, SHIFT) and the default WIDTH constant are defined in the shared serdesphy package and are reused by the matching deserializer.
REQ-028 The block is one module with no sub-modules; the holding register, shift register, counter and FSM live in a single always block per register group.

Verification
REQ-029 Single word: enable=1, accept 0xA5C3 once -> serial_out = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on cycles 1..16 after accept, then 0; underrun pulses at cycle 17; busy high on cycles 1..16.
REQ-030 Back-to-back: accept 0xFFFF then 0x0000 as soon as data_ready allows -> 32 contiguous bits (16 ones, 16 zeros), no underrun until after bit 31; data_ready low while the holding register is full.
REQ-031 Bypass corner: hold data_valid low until the bit-15 cycle of word 0x8001, then present 0x0001 -> accept occurs on that edge, stream is gapless, no underrun pulse.
REQ-032 Abort: enable drops after bit 5 of 0x1234 with 0x5678 held -> serial_out 0 next cycle, busy 0, data_ready 0, underrun never pulses; re-enable and send 0x00FF -> correct 16 bits.
REQ-033 Async reset mid-word: assert rst_n=0 between clock edges during bit 9 -> all outputs reach reset values without a clock edge; after release, first accept serializes correctly.
REQ-034 Loopback: connect serial_out to serdesphy_ana_deserializer with 1000 random words streamed gaplessly -> every parallel_out matches the transmitted word in order.
